// File: rtl/nibble_sort4.sv
// -----------------------------------------------------------------------------
// nibble_sort4
//
// Collects a burst of DEPTH 4-bit values and bubble-sorts them in place. Each
// compare is done by an external 4-bit magnitude comparator that sits beside
// this block. The sorted burst is then streamed out.
//
// The sort always runs all DEPTH*(DEPTH-1)/2 compare cycles. There is no early
// exit, so the latency is the same for every burst. Equal values are never
// swapped, which makes the sort stable.
//
// Parameters
//   DEPTH    values per burst (2..8)
//   DESCEND  0 = ascending output order, 1 = descending output order
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; discards any burst in flight
//   in_valid_i   in_data_i holds a value
//   in_data_i    unsigned 4-bit value to load
//   in_ready_o   block accepts a value this cycle (LOAD only)
//   cmp_a_o      comparator operand a (buf[i] during SORT, else 0)
//   cmp_b_o      comparator operand b (buf[i+1] during SORT, else 0)
//   cmp_eq_i     comparator result a == b, same cycle
//   cmp_lt_i     comparator result a <  b, same cycle
//   out_valid_o  out_data_o holds a sorted value (DRAIN only)
//   out_data_o   sorted value
//   out_last_o   final value of the burst
//   out_ready_i  downstream accepts out_data_o
//   busy_o       high while sorting or draining
// -----------------------------------------------------------------------------
module nibble_sort4 #(
    parameter int DEPTH   = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    input  logic [3:0] in_data_i,
    output logic       in_ready_o,
    output logic [3:0] cmp_a_o,
    output logic [3:0] cmp_b_o,
    input  logic       cmp_eq_i,
    input  logic       cmp_lt_i,
    output logic       out_valid_o,
    output logic [3:0] out_data_o,
    output logic       out_last_o,
    input  logic       out_ready_i,
    output logic       busy_o
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    buf_q [DEPTH];
    logic [IW-1:0] wr_idx_q;
    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] pass_q;
    logic [IW-1:0] cmp_idx_q;

    // Handshake and status flags are kept as registers that change together
    // with the state, so no output depends on in_valid_i or out_ready_i.
    logic          in_ready_q;
    logic          busy_q;
    logic          out_valid_q;
    logic          out_last_q;

    logic [IW-1:0] wr_idx_d;
    logic [IW-1:0] rd_idx_d;
    logic [IW-1:0] pass_d;
    logic [IW-1:0] cmp_idx_d;
    logic [IW-1:0] pass_end_idx;
    logic          in_fire;
    logic          out_fire;
    logic          do_swap;
    logic          pass_done;
    logic          sort_done;

    assign wr_idx_d  = wr_idx_q + 1'b1;
    assign rd_idx_d  = rd_idx_q + 1'b1;
    assign pass_d    = pass_q + 1'b1;
    assign cmp_idx_d = cmp_idx_q + 1'b1;

    // Each pass bubbles one value into its final slot at the top, so the
    // compare range shrinks by one every pass: i runs 0..DEPTH-2-p.
    assign pass_end_idx = LAST_PASS - pass_q;
    assign pass_done    = (cmp_idx_q == pass_end_idx);
    assign sort_done    = pass_done && (pass_q == LAST_PASS);

    assign in_fire  = in_valid_i && in_ready_q;
    assign out_fire = out_valid_q && out_ready_i;

    // Swap only on a strict ordering violation so that equal values keep
    // their arrival order.
    assign do_swap = DESCEND ? cmp_lt_i : (!cmp_lt_i && !cmp_eq_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pass_q      <= '0;
            cmp_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        buf_q[wr_idx_q] <= in_data_i;
                        if (wr_idx_q == LAST_IDX) begin
                            state_q    <= SORT;
                            wr_idx_q   <= '0;
                            pass_q     <= '0;
                            cmp_idx_q  <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_d;
                        end
                    end
                end

                SORT: begin
                    if (do_swap) begin
                        buf_q[cmp_idx_q] <= buf_q[cmp_idx_d];
                        buf_q[cmp_idx_d] <= buf_q[cmp_idx_q];
                    end
                    if (pass_done) begin
                        cmp_idx_q <= '0;
                        if (sort_done) begin
                            state_q     <= DRAIN;
                            pass_q      <= '0;
                            rd_idx_q    <= '0;
                            out_valid_q <= 1'b1;
                            // DEPTH >= 2, so the first drained value is
                            // never the last one.
                            out_last_q  <= 1'b0;
                        end else begin
                            pass_q <= pass_d;
                        end
                    end else begin
                        cmp_idx_q <= cmp_idx_d;
                    end
                end

                DRAIN: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            // Back to LOAD with in_ready already high in the
                            // next cycle: no bubble between bursts.
                            state_q     <= LOAD;
                            rd_idx_q    <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            rd_idx_q   <= rd_idx_d;
                            out_last_q <= (rd_idx_d == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state_q     <= LOAD;
                    wr_idx_q    <= '0;
                    rd_idx_q    <= '0;
                    pass_q      <= '0;
                    cmp_idx_q   <= '0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand and data muxes are driven from registered state only. They are
    // forced to zero outside their own phase, so reset clears them at once.
    assign cmp_a_o    = (state_q == SORT) ? buf_q[cmp_idx_q] : 4'd0;
    assign cmp_b_o    = (state_q == SORT) ? buf_q[cmp_idx_d] : 4'd0;
    assign out_data_o = out_valid_q ? buf_q[rd_idx_q] : 4'd0;

    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_nibble_sort4.sv
// -----------------------------------------------------------------------------
// tb_nibble_sort4
//
// Drives an ascending instance and a descending instance of nibble_sort4 with
// the same stimulus. A comparator model sits beside each instance. Each
// instance also has a transaction-level model: a queue of the compare pairs
// still expected and a queue of the sorted outputs still expected. A single
// negedge process compares every DUT output against these models on every
// cycle. Literal expectations pin both the model functions and the streams
// the DUTs produce.
// -----------------------------------------------------------------------------
module tb_nibble_sort4;

    localparam int DEPTH = 4;
    localparam int NCMP  = DEPTH * (DEPTH - 1) / 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [3:0] in_data   = 4'd0;
    logic       out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Value j of a burst lives at bits [4j+3:4j].
    function automatic logic [15:0] p4(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    // Reference order by counting values: walk the value range in the output
    // direction and emit every value of the burst that matches.
    function automatic logic [15:0] sort_ref(input logic [15:0] v, input bit desc);
        logic [15:0] r = '0;
        int n = 0;
        for (int s = 0; s < 16; s++) begin
            int val = desc ? 15 - s : s;
            for (int j = 0; j < DEPTH; j++) begin
                if (int'(v[4*j +: 4]) == val) begin
                    r[4*n +: 4] = v[4*j +: 4];
                    n++;
                end
            end
        end
        return r;
    endfunction

    // Operand pairs the sorter must show to the comparator, in order. These
    // come from a plain bubble sort over an array. Pair c is at bits
    // [8c+7:8c] as {a, b}.
    function automatic logic [47:0] cmp_ref(input logic [15:0] v, input bit desc);
        logic [3:0]  a [DEPTH];
        logic [3:0]  t;
        logic [47:0] r = '0;
        int c = 0;
        for (int j = 0; j < DEPTH; j++) a[j] = v[4*j +: 4];
        for (int p = 0; p < DEPTH - 1; p++) begin
            for (int i = 0; i < DEPTH - 1 - p; i++) begin
                r[8*c +: 8] = {a[i], a[i+1]};
                c++;
                if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic       in_ready, busy, out_valid, out_last, cmp_eq, cmp_lt;
        logic [3:0] out_data, cmp_a, cmp_b;

        nibble_sort4 #(.DEPTH(DEPTH), .DESCEND(gi == 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid_i (in_valid),
            .in_data_i  (in_data),
            .in_ready_o (in_ready),
            .cmp_a_o    (cmp_a),
            .cmp_b_o    (cmp_b),
            .cmp_eq_i   (cmp_eq),
            .cmp_lt_i   (cmp_lt),
            .out_valid_o(out_valid),
            .out_data_o (out_data),
            .out_last_o (out_last),
            .out_ready_i(out_ready),
            .busy_o     (busy)
        );

        assign cmp_eq = (cmp_a == cmp_b);
        assign cmp_lt = (cmp_a < cmp_b);

        // Transaction model: pending compares, then pending outputs, else idle.
        logic [7:0]  cmp_q [$];
        logic [3:0]  out_q [$];
        logic [15:0] acc = '0;
        int          cnt = 0;
        logic [47:0] pairs;
        logic [15:0] srt;
        logic        exp_sort = 1'b0, exp_drain = 1'b0, exp_last = 1'b0;
        logic [7:0]  exp_cmp = '0;
        logic [3:0]  exp_out = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmp_q.delete();
                out_q.delete();
                acc = '0;
                cnt = 0;
            end else if (cmp_q.size() != 0) begin
                void'(cmp_q.pop_front());
            end else if (out_q.size() != 0) begin
                if (out_ready) void'(out_q.pop_front());
            end else if (in_valid) begin
                acc[4*cnt +: 4] = in_data;
                cnt++;
                if (cnt == DEPTH) begin
                    pairs = cmp_ref(acc, gi == 1);
                    srt   = sort_ref(acc, gi == 1);
                    for (int c = 0; c < NCMP; c++) cmp_q.push_back(pairs[8*c +: 8]);
                    for (int j = 0; j < DEPTH; j++) out_q.push_back(srt[4*j +: 4]);
                    cnt = 0;
                end
            end
            exp_sort  = (cmp_q.size() != 0);
            exp_drain = !exp_sort && (out_q.size() != 0);
            exp_cmp   = exp_sort ? cmp_q[0] : 8'h00;
            exp_out   = exp_drain ? out_q[0] : 4'd0;
            exp_last  = exp_drain && (out_q.size() == 1);
        end

        // Log of values the DUT actually handed over.
        logic [3:0] log_mem [64];
        int         log_n = 0;
        always @(posedge clk) begin
            if (rst_n && out_valid && out_ready) begin
                log_mem[log_n % 64] = out_data;
                log_n++;
            end
        end
    end

    task automatic check_inst(input string tag, input logic es, input logic ed,
                              input logic [7:0] ec, input logic [3:0] eo, input logic el,
                              input logic ir, input logic bsy, input logic ov,
                              input logic ol, input logic [3:0] od,
                              input logic [3:0] ca, input logic [3:0] cb);
        chk({tag, "_in_ready"},  ir, !es && !ed);
        chk({tag, "_busy"},      bsy, es || ed);
        chk({tag, "_out_valid"}, ov, ed);
        chk({tag, "_out_last"},  ol, el);
        chk({tag, "_cmp_a"},     ca, ec[7:4]);
        chk({tag, "_cmp_b"},     cb, ec[3:0]);
        if (ed) chk({tag, "_out_data"}, od, eo);
    endtask

    always @(negedge clk) begin
        check_inst("asc", g_dut[0].exp_sort, g_dut[0].exp_drain, g_dut[0].exp_cmp,
                   g_dut[0].exp_out, g_dut[0].exp_last, g_dut[0].in_ready, g_dut[0].busy,
                   g_dut[0].out_valid, g_dut[0].out_last, g_dut[0].out_data,
                   g_dut[0].cmp_a, g_dut[0].cmp_b);
        check_inst("desc", g_dut[1].exp_sort, g_dut[1].exp_drain, g_dut[1].exp_cmp,
                   g_dut[1].exp_out, g_dut[1].exp_last, g_dut[1].in_ready, g_dut[1].busy,
                   g_dut[1].out_valid, g_dut[1].out_last, g_dut[1].out_data,
                   g_dut[1].cmp_a, g_dut[1].cmp_b);
    end

    task automatic reset_vals(input string tag, input logic ir, input logic bsy,
                              input logic ov, input logic ol, input logic [3:0] od,
                              input logic [3:0] ca, input logic [3:0] cb);
        chk({tag, "_in_ready"},  ir, 1);
        chk({tag, "_busy"},      bsy, 0);
        chk({tag, "_out_valid"}, ov, 0);
        chk({tag, "_out_last"},  ol, 0);
        chk({tag, "_out_data"},  od, 0);
        chk({tag, "_cmp_a"},     ca, 0);
        chk({tag, "_cmp_b"},     cb, 0);
    endtask

    task automatic reset_chk(input string tag);
        reset_vals({tag, "_asc"}, g_dut[0].in_ready, g_dut[0].busy, g_dut[0].out_valid,
                   g_dut[0].out_last, g_dut[0].out_data, g_dut[0].cmp_a, g_dut[0].cmp_b);
        reset_vals({tag, "_desc"}, g_dut[1].in_ready, g_dut[1].busy, g_dut[1].out_valid,
                   g_dut[1].out_last, g_dut[1].out_data, g_dut[1].cmp_a, g_dut[1].cmp_b);
    endtask

    // Called at a negedge. Offers one value until it is accepted and returns
    // at the negedge right after the accepting edge.
    task automatic push(input logic [3:0] v);
        int n = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!g_dut[0].in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_burst(input logic [15:0] v);
        for (int j = 0; j < DEPTH; j++) push(v[4*j +: 4]);
    endtask

    // Counts cycles from the last accept until out_valid rises.
    task automatic latency_chk(input string name);
        int n = 0;
        while (!g_dut[0].out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, NCMP);
    endtask

    // Waits out SORT, then drains with out_ready following pat (plen bits,
    // repeating). With pulse set, in_valid toggles at random until the final
    // value is about to be handed over.
    task automatic drain(input int target, input bit pulse, input logic [7:0] pat,
                         input int plen);
        int n = 0;
        int k = 0;
        while (!g_dut[0].out_valid && n < 50) begin
            in_valid = pulse && ($urandom_range(0, 1) == 1);
            in_data  = 4'($urandom);
            @(negedge clk);
            n++;
        end
        while (g_dut[0].log_n < target && n < 100) begin
            out_ready = pat[k % plen];
            k++;
            in_valid  = pulse && (g_dut[0].log_n < target - 1) && ($urandom_range(0, 1) == 1);
            in_data   = 4'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("drain_count", g_dut[0].log_n, target);
    endtask

    task automatic log_chk(input string name, input int start, input logic [15:0] e_asc,
                           input logic [15:0] e_desc);
        for (int j = 0; j < DEPTH; j++) begin
            chk($sformatf("%s_asc_v%0d", name, j), g_dut[0].log_mem[(start + j) % 64], e_asc[4*j +: 4]);
            chk($sformatf("%s_desc_v%0d", name, j), g_dut[1].log_mem[(start + j) % 64], e_desc[4*j +: 4]);
        end
    endtask

    initial begin
        int start;
        bit acc_now, last_now;

        // Pin the model functions against hand-worked values.
        chk("pin_sort_asc",  sort_ref(p4(9, 3, 12, 3), 1'b0), p4(3, 3, 9, 12));
        chk("pin_sort_desc", sort_ref(p4(0, 15, 7, 7), 1'b1), p4(15, 7, 7, 0));
        chk("pin_cmp_seq",   cmp_ref(p4(9, 3, 12, 3), 1'b0),
            {8'h33, 8'h93, 8'h39, 8'hC3, 8'h9C, 8'h93});

        // Reset state.
        repeat (2) @(negedge clk);
        reset_chk("reset");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Ascending example; latency from last accept to out_valid.
        start = g_dut[0].log_n;
        push_burst(p4(9, 3, 12, 3));
        latency_chk("latency_9_3_12_3");
        drain(start + DEPTH, 1'b0, 8'h01, 1);
        log_chk("burst_9_3_12_3", start, p4(3, 3, 9, 12), p4(12, 9, 3, 3));

        // Backpressure 0,1,0,0,1 and in_valid pulses while busy.
        start = g_dut[0].log_n;
        push_burst(p4(0, 15, 7, 7));
        drain(start + DEPTH, 1'b1, 8'b0001_0010, 5);
        log_chk("burst_0_15_7_7", start, p4(0, 7, 7, 15), p4(15, 7, 7, 0));

        // Already-sorted input still takes the full compare sequence.
        start = g_dut[0].log_n;
        push_burst(p4(1, 2, 3, 4));
        latency_chk("latency_sorted");
        drain(start + DEPTH, 1'b0, 8'h01, 1);
        log_chk("burst_1_2_3_4", start, p4(1, 2, 3, 4), p4(4, 3, 2, 1));

        // Back-to-back bursts with in_valid held high: 2 x 14 cycles.
        start    = g_dut[0].log_n;
        in_valid = 1'b1;
        in_data  = 4'($urandom);
        for (int c = 0; c < 2 * (2 * DEPTH + NCMP); c++) begin
            acc_now  = g_dut[0].in_ready;
            last_now = g_dut[0].out_valid && g_dut[0].out_last;
            @(negedge clk);
            if (last_now) chk("turnaround_in_ready", g_dut[0].in_ready, 1);
            if (acc_now) in_data = 4'($urandom);
        end
        in_valid = 1'b0;
        chk("b2b_output_count", g_dut[0].log_n - start, 2 * DEPTH);

        // Random traffic with random gaps and backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Clean reset, then reset asserted mid-SORT after three compares.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_burst(p4(3, 8, 1, 6));
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_chk("reset_mid_sort");
        @(negedge clk);
        rst_n = 1'b1;

        start = g_dut[0].log_n;
        push_burst(p4(5, 1, 4, 2));
        drain(start + DEPTH, 1'b0, 8'h01, 1);
        log_chk("burst_5_1_4_2", start, p4(1, 2, 4, 5), p4(5, 4, 2, 1));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
